// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the DataMem port between the CPU (priority) and a loader with bounded wait and burst
module data_mem_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic [3:0]        ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam logic [0:0] CPU_OWN = 1'b0;
  localparam logic [0:0] LD_OWN  = 1'b1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP  = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BURST_TOP = BW'(BURST_MAX - 1);
  logic [0:0]    owner;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          ld_own;
  logic          ld_read;
  assign ld_own  = owner == LD_OWN;
  assign ld_read = ld_gnt && ld_we == 4'h0;
  always_comb begin
    mem_en    = !rst && (ld_own ? ld_req : cpu_en);
    mem_we    = rst ? 4'h0 : ld_own ? (ld_req ? ld_we : 4'h0) : cpu_we;
    mem_addr  = ld_own ? ld_addr : cpu_addr;
    mem_wdata = ld_own ? ld_wdata : cpu_wdata;
    cpu_rdata = ld_own ? 32'h0 : mem_rdata;
    cpu_stall = !rst && ld_own && cpu_en;
    ld_gnt    = !rst && ld_own && ld_req;
  end
  always_ff @(posedge clk)
    if (rst) begin
      owner     <= CPU_OWN;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= 32'h0;
    end else begin
      ld_rvalid <= ld_read;
      if (ld_read) ld_rdata <= mem_rdata;
      if (!ld_own) begin
        wait_cnt <= !ld_req ? '0 : (cpu_en && wait_cnt != WAIT_TOP) ? wait_cnt + 1'b1 : wait_cnt;
        if (ld_req && (!cpu_en || wait_cnt == WAIT_TOP)) begin
          owner     <= LD_OWN;
          burst_cnt <= '0;
        end
      end else if (ld_req && !(cpu_en && burst_cnt == BURST_TOP))
        burst_cnt <= burst_cnt == BURST_TOP ? burst_cnt : burst_cnt + 1'b1;
      else begin
        owner    <= CPU_OWN;
        wait_cnt <= '0;
      end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized scoreboard bench for data_mem_arbiter against a cycle-level reference model
module tb_data_mem_arbiter;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_we = 4'h0;
  logic [10:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ld_req = 1'b0;
  logic [3:0]  ld_we = 4'h0;
  logic [10:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  bit   [31:0] dmem [0:2047];
  bit   [31:0] ref_mem [0:2047];
  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] ld_rdata;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  bit m_ld = 0;
  int m_wait = 0;
  int m_burst = 0;
  bit m_rvalid = 0;
  bit [31:0] m_rdata = 0;
  bit last_gnt = 0;
  int stall_run = 0;
  int ld_run = 0;

  data_mem_arbiter #(.ADDR_W(11), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk)
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk("mem_en", 32'(mem_en), 32'(e.en));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      if (e.en) begin
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", mem_wdata, e.wdata);
      end
      chk("cpu_rdata", cpu_rdata, e.cpu_rdata);
      chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
      chk("ld_gnt", 32'(ld_gnt), 32'(e.gnt));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(e.rvalid));
      chk("ld_rdata", ld_rdata, e.ld_rdata);
    end
    stall_run = (rst || !cpu_stall) ? 0 : stall_run + 1;
    ld_run = (rst || !ld_req || ld_gnt) ? 0 : ld_run + 1;
    if (stall_run > BURST_MAX) begin
      n_err++;
      $display("FAIL stall_bound: got %0d consecutive stalls, limit %0d", stall_run, BURST_MAX);
    end
    if (ld_run > MAX_WAIT + 1) begin
      n_err++;
      $display("FAIL loader_wait_bound: got %0d waiting cycles, limit %0d", ld_run, MAX_WAIT + 1);
    end
  end

  // One clock of the reference model: predict this cycle's outputs, then advance state at the edge.
  task automatic cycle();
    exp_t e;
    e.en        = !rst && (m_ld ? ld_req : cpu_en);
    e.we        = rst ? 4'h0 : m_ld ? (ld_req ? ld_we : 4'h0) : cpu_we;
    e.addr      = m_ld ? ld_addr : cpu_addr;
    e.wdata     = m_ld ? ld_wdata : cpu_wdata;
    e.cpu_rdata = m_ld ? 32'h0 : ref_mem[cpu_addr];
    e.stall     = !rst && m_ld && cpu_en;
    e.gnt       = !rst && m_ld && ld_req;
    e.rvalid    = m_rvalid;
    e.ld_rdata  = m_rdata;
    q.push_back(e);
    last_gnt = e.gnt;
    @(posedge clk);
    if (rst) begin
      m_ld = 0; m_wait = 0; m_burst = 0; m_rvalid = 0; m_rdata = 0;
    end else begin
      m_rvalid = e.gnt && ld_we == 4'h0;
      if (m_rvalid) m_rdata = ref_mem[ld_addr];
      if (e.en)
        for (int b = 0; b < 4; b++)
          if (e.we[b]) ref_mem[e.addr][8*b +: 8] = e.wdata[8*b +: 8];
      if (!m_ld) begin
        if (ld_req && (!cpu_en || m_wait == MAX_WAIT - 1)) begin
          m_ld = 1;
          m_burst = 0;
        end
        m_wait = !ld_req ? 0 : cpu_en ? ((m_wait + 1 > MAX_WAIT - 1) ? MAX_WAIT - 1 : m_wait + 1) : m_wait;
      end else if (ld_req && !(cpu_en && m_burst == BURST_MAX - 1))
        m_burst = (m_burst + 1 > BURST_MAX - 1) ? BURST_MAX - 1 : m_burst + 1;
      else begin
        m_ld = 0;
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic ld_op(input logic [3:0] we, input logic [10:0] addr, input logic [31:0] wd);
    bit done = 0;
    ld_req = 1; ld_we = we; ld_addr = addr; ld_wdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_gnt;
    end
    if (!done) begin
      n_err++;
      $display("FAIL ld_op_timeout: got no grant, required grant within 20 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    bit pend = 0;
    int grants;
    @(posedge clk);
    #1;
    // reset with a CPU write pending: nothing may reach memory
    rst = 1; cpu_en = 1; cpu_we = 4'hF; cpu_addr = 11'h010; cpu_wdata = 32'h12345678;
    repeat (2) cycle();
    rst = 0; cpu_wdata = 32'hDEADBEEF;
    cycle();
    cpu_we = 4'h0;
    cycle();
    cpu_en = 0;
    ld_op(4'h0, 11'h010, 32'h0);
    ld_req = 0;
    repeat (2) cycle();
    // CPU and loader both busy: forced grant, bounded burst, repeat
    cpu_en = 1; ld_req = 1; ld_we = 4'h0; ld_addr = 11'h010;
    for (int i = 0; i < 30; i++) begin
      cpu_addr = 11'($urandom_range(0, 63));
      cycle();
    end
    ld_req = 0; cpu_en = 0;
    cycle();
    for (int k = 0; k < 3; k++) ld_op(4'hF, 11'(32 + k), $urandom);
    ld_req = 0;
    cycle();
    cpu_en = 1; cpu_we = 4'h0;
    for (int k = 0; k < 3; k++) begin
      cpu_addr = 11'(32 + k);
      cycle();
    end
    // reset lands on the third grant of a loader read burst
    cpu_en = 0; ld_req = 1; ld_we = 4'h0; ld_addr = 11'h021;
    grants = 0;
    for (int i = 0; i < 10 && grants < 2; i++) begin
      cycle();
      grants += int'(last_gnt);
    end
    rst = 1;
    cycle();
    rst = 0; ld_req = 0;
    repeat (2) cycle();
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      cpu_en = $urandom_range(0, 3) != 0;
      cpu_we = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0;
      cpu_addr = 11'($urandom_range(0, 63));
      cpu_wdata = $urandom;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        ld_we = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom);
        ld_addr = 11'($urandom_range(0, 63));
        ld_wdata = $urandom;
      end
      ld_req = pend;
      cycle();
      if (last_gnt) pend = 0;
    end
    rst = 0; cpu_en = 0; ld_req = 0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
